// File: rtl/pit_pkg.sv
// Shared constants and types for the programmable interval timer.
package pit_pkg;

    localparam logic [1:0] MODE_TC     = 2'd0;
    localparam logic [1:0] MODE_RATE   = 2'd2;
    localparam logic [1:0] MODE_SQUARE = 2'd3;

    typedef enum logic [1:0] {
        RW_LATCH = 2'b00,
        RW_LSB   = 2'b01,
        RW_MSB   = 2'b10,
        RW_BOTH  = 2'b11
    } rw_e;

    localparam logic [1:0] ADR_CH0  = 2'd0;
    localparam logic [1:0] ADR_CH1  = 2'd1;
    localparam logic [1:0] ADR_CH2  = 2'd2;
    localparam logic [1:0] ADR_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COUNTING  = 2'd2
    } chan_state_e;

    // Unsupported modes fold onto the nearest supported behaviour.
    function automatic logic [1:0] map_mode(input logic [2:0] m);
        case (m)
            3'd2, 3'd6: map_mode = MODE_RATE;
            3'd3, 3'd7: map_mode = MODE_SQUARE;
            default:    map_mode = MODE_TC;
        endcase
    endfunction

endpackage

// File: rtl/pit_if.sv
// Wishbone peripheral-side bundle for the interval timer.
interface pit_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/pit_channel.sv
// One 16-bit down-counter with pending count, read latch, byte pointers and
// the mode 0/2/3 output behaviour.
module pit_channel
    import pit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       ctrl_we_i,
    input  logic [1:0] rw_i,
    input  logic [2:0] mode_i,
    input  logic       latch_i,
    input  logic       wr_i,
    input  logic       rd_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       out_o
);

    chan_state_e state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    rw_e         rw_q, rw_d;
    logic [15:0] count_q, count_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] latch_q, latch_d;
    logic        pend_valid_q, pend_valid_d;
    logic        latched_q, latched_d;
    logic [7:0]  lsb_q, lsb_d;
    logic        wr_msb_q, wr_msb_d;
    logic        rd_msb_q, rd_msb_d;
    logic        out_q, out_d;

    logic [15:0] nxt_cnt, nxt_rel, wr_val, src;
    logic        wr_done;
    logic [1:0]  new_mode;

    assign new_mode = map_mode(mode_i);

    function automatic logic [15:0] eff_count(input logic [1:0] mode, input logic [15:0] n);
        eff_count = (mode != MODE_TC && n == 16'd1) ? 16'd2 : n;
    endfunction

    // A stored 0 stands for 65536, hence the 17-bit comparison for mode 3.
    function automatic logic periodic_out(input logic [1:0] mode, input logic [15:0] cnt,
                                          input logic [15:0] rel);
        logic [16:0] c;
        logic [16:0] r;
        c = (cnt == 16'd0) ? 17'h10000 : {1'b0, cnt};
        r = (rel == 16'd0) ? 17'h10000 : {1'b0, rel};
        if (mode == MODE_SQUARE) periodic_out = (c > (r >> 1));
        else                     periodic_out = (cnt != 16'd1);
    endfunction

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        rw_d         = rw_q;
        count_d      = count_q;
        reload_d     = reload_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        latch_d      = latch_q;
        latched_d    = latched_q;
        lsb_d        = lsb_q;
        wr_msb_d     = wr_msb_q;
        rd_msb_d     = rd_msb_q;
        out_d        = out_q;
        nxt_cnt      = count_q;
        nxt_rel      = reload_q;
        wr_val       = 16'h0000;
        wr_done      = 1'b0;

        if (tick_i) begin
            case (state_q)
                WAIT_LOAD: begin
                    if (pend_valid_q) begin
                        nxt_cnt      = eff_count(mode_q, pending_q);
                        nxt_rel      = nxt_cnt;
                        pend_valid_d = 1'b0;
                        state_d      = COUNTING;
                        count_d      = nxt_cnt;
                        reload_d     = nxt_rel;
                        out_d        = (mode_q == MODE_TC) ? 1'b0
                                                           : periodic_out(mode_q, nxt_cnt, nxt_rel);
                    end
                end
                COUNTING: begin
                    if (mode_q == MODE_TC) begin
                        count_d = count_q - 16'd1;
                        if (count_q == 16'd1) out_d = 1'b1;
                    end else begin
                        if (count_q == 16'd1) begin
                            if (pend_valid_q) begin
                                nxt_rel      = eff_count(mode_q, pending_q);
                                pend_valid_d = 1'b0;
                            end
                            nxt_cnt = nxt_rel;
                        end else begin
                            nxt_cnt = count_q - 16'd1;
                        end
                        count_d  = nxt_cnt;
                        reload_d = nxt_rel;
                        out_d    = periodic_out(mode_q, nxt_cnt, nxt_rel);
                    end
                end
                default: ;
            endcase
        end

        // Bus actions are applied after the tick so they take priority.
        if (ctrl_we_i) begin
            mode_d       = new_mode;
            rw_d         = rw_e'(rw_i);
            wr_msb_d     = 1'b0;
            rd_msb_d     = 1'b0;
            latched_d    = 1'b0;
            pend_valid_d = 1'b0;
            state_d      = IDLE;
            out_d        = (new_mode == MODE_TC) ? 1'b0 : 1'b1;
        end

        if (latch_i && !latched_q) begin
            latch_d   = count_q;
            latched_d = 1'b1;
            rd_msb_d  = 1'b0;
        end

        if (wr_i) begin
            case (rw_q)
                RW_LSB: begin
                    wr_val  = {8'h00, wdata_i};
                    wr_done = 1'b1;
                end
                RW_MSB: begin
                    wr_val  = {wdata_i, 8'h00};
                    wr_done = 1'b1;
                end
                RW_BOTH: begin
                    if (wr_msb_q) begin
                        wr_val   = {wdata_i, lsb_q};
                        wr_done  = 1'b1;
                        wr_msb_d = 1'b0;
                    end else begin
                        lsb_d    = wdata_i;
                        wr_msb_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (mode_q == MODE_TC && rw_q != RW_LATCH) out_d = 1'b0;
            if (wr_done) begin
                pending_d    = wr_val;
                pend_valid_d = 1'b1;
                if (state_q == IDLE || mode_q == MODE_TC) state_d = WAIT_LOAD;
            end
        end

        if (rd_i) begin
            if (rw_q == RW_BOTH) begin
                rd_msb_d = ~rd_msb_q;
                if (rd_msb_q) latched_d = 1'b0;
            end else begin
                latched_d = 1'b0;
            end
        end
    end

    always_comb begin
        src = latched_q ? latch_q : count_q;
        case (rw_q)
            RW_MSB:  rdata_o = src[15:8];
            RW_BOTH: rdata_o = rd_msb_q ? src[15:8] : src[7:0];
            default: rdata_o = src[7:0];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= MODE_TC;
            rw_q         <= RW_LATCH;
            count_q      <= 16'h0000;
            reload_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            latch_q      <= 16'h0000;
            pend_valid_q <= 1'b0;
            latched_q    <= 1'b0;
            lsb_q        <= 8'h00;
            wr_msb_q     <= 1'b0;
            rd_msb_q     <= 1'b0;
            out_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            rw_q         <= rw_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            pending_q    <= pending_d;
            latch_q      <= latch_d;
            pend_valid_q <= pend_valid_d;
            latched_q    <= latched_d;
            lsb_q        <= lsb_d;
            wr_msb_q     <= wr_msb_d;
            rd_msb_q     <= rd_msb_d;
            out_q        <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pit_top.sv
// Three-channel interval timer: Wishbone decode, ack/read-data registers and
// the shared tick prescaler.
module pit_top
    import pit_pkg::*;
#(
    parameter int PRESCALE = 1
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    pit_if.slave       bus,
    output logic [2:0] out_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;

    logic          access, honoured, wr_acc, rd_acc, ctrl_hit;
    logic [1:0]    reg_sel;
    logic [2:0]    ch_ctrl_we, ch_latch, ch_wr, ch_rd;
    logic [2:0][7:0] ch_rdata;
    logic          bus_unused;

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // An access fires once; the ack cycle itself blocks re-execution.
    assign access   = bus.cyc_i & bus.stb_i & ~ack_q;
    assign honoured = access & bus.sel_i[0];
    assign wr_acc   = honoured & bus.we_i;
    assign rd_acc   = honoured & ~bus.we_i;
    assign reg_sel  = bus.adr_i[3:2];
    assign ctrl_hit = wr_acc && (reg_sel == ADR_CTRL) && (bus.dat_i[7:6] != 2'b11);

    assign bus_unused = ^{bus.sel_i[3:1], bus.adr_i[31:4], bus.adr_i[1:0],
                          bus.dat_i[31:8], bus.dat_i[0]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            assign ch_ctrl_we[gi] = ctrl_hit && (bus.dat_i[7:6] == 2'(gi))
                                    && (bus.dat_i[5:4] != RW_LATCH);
            assign ch_latch[gi]   = ctrl_hit && (bus.dat_i[7:6] == 2'(gi))
                                    && (bus.dat_i[5:4] == RW_LATCH);
            assign ch_wr[gi]      = wr_acc && (reg_sel == 2'(gi));
            assign ch_rd[gi]      = rd_acc && (reg_sel == 2'(gi));

            pit_channel u_ch (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .tick_i    (tick),
                .ctrl_we_i (ch_ctrl_we[gi]),
                .rw_i      (bus.dat_i[5:4]),
                .mode_i    (bus.dat_i[3:1]),
                .latch_i   (ch_latch[gi]),
                .wr_i      (ch_wr[gi]),
                .rd_i      (ch_rd[gi]),
                .wdata_i   (bus.dat_i[7:0]),
                .rdata_o   (ch_rdata[gi]),
                .out_o     (out_o[gi])
            );
        end
    endgenerate

    always_comb begin
        ack_d = access;
        dat_d = dat_q;
        if (access) begin
            dat_d = 32'h0;
            if (rd_acc) begin
                case (reg_sel)
                    ADR_CH0: dat_d = {24'h0, ch_rdata[0]};
                    ADR_CH1: dat_d = {24'h0, ch_rdata[1]};
                    ADR_CH2: dat_d = {24'h0, ch_rdata[2]};
                    default: dat_d = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            presc_q <= presc_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_pit_top.sv
// Directed bench for pit_top with PRESCALE=1; every check goes through chk().
module tb_pit_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] out;
    int         total = 0;
    int         bad = 0;

    pit_if bus_if ();

    pit_top #(.PRESCALE(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if),
        .out_o (out)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One Wishbone access; executes on the first edge, returns #1 after the ack cycle.
    task automatic wb(input logic we, input logic [1:0] a, input logic [7:0] d,
                      input logic [3:0] sel, output logic [31:0] rdat);
        @(negedge clk);
        bus_if.cyc_i = 1'b1;
        bus_if.stb_i = 1'b1;
        bus_if.we_i  = we;
        bus_if.sel_i = sel;
        bus_if.adr_i = {28'h0, a, 2'b00};
        bus_if.dat_i = {24'h0, d};
        @(posedge clk);
        #1;
        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        bus_if.we_i  = 1'b0;
        chk("ack", {31'h0, bus_if.ack_o}, 32'h1);
        rdat = bus_if.dat_o;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [31:0] dummy;
        wb(1'b1, a, d, 4'h1, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [31:0] v;
        wb(1'b0, a, 8'h00, 4'h1, v);
        chk(tag, v, {24'h0, exp});
    endtask

    initial begin
        logic [15:0] v16;
        logic [14:0] v15;
        logic [11:0] v12;
        logic [3:0]  ackv;
        logic [31:0] dummy;
        int          edges;
        int          first_low;
        logic        prev;
        logic        last;

        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        bus_if.we_i  = 1'b0;
        bus_if.sel_i = 4'h0;
        bus_if.adr_i = 32'h0;
        bus_if.dat_i = 32'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out", {29'h0, out}, 32'h0);
        chk("rst_ack", {31'h0, bus_if.ack_o}, 32'h0);
        chk("rst_dat", bus_if.dat_o, 32'h0);
        rd_chk("rst_rd_ch0", 2'd0, 8'h00);
        rd_chk("rd_ctrl", 2'd3, 8'h00);

        // Mode 0 on ch0, count 5
        wr(2'd3, 8'h30);
        wr(2'd0, 8'h05);
        wr(2'd0, 8'h00);
        chk("m0_load_low", {31'h0, out[0]}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("m0_tick%0d", k), {31'h0, out[0]}, (k == 5) ? 32'h1 : 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("m0_hold_high", {31'h0, out[0]}, 32'h1);
        wr(2'd0, 8'h05);
        wr(2'd0, 8'h00);
        chk("m0_rewrite_low", {31'h0, out[0]}, 32'h0);

        // Mode 2 on ch1, count 4
        wr(2'd3, 8'h74);
        wr(2'd1, 8'h04);
        wr(2'd1, 8'h00);
        chk("m2_load_high", {31'h0, out[1]}, 32'h1);
        prev  = out[1];
        edges = 0;
        v16   = '0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            v16[k-1] = out[1];
            if (out[1] && !prev) edges++;
            prev = out[1];
        end
        chk("m2_pattern", {16'h0, v16}, 32'h0000BBBB);
        chk("m2_edges", edges, 32'd4);

        // Mode 3 on ch2, count 5 then 6
        wr(2'd3, 8'hB6);
        wr(2'd2, 8'h05);
        wr(2'd2, 8'h00);
        v15    = '0;
        v15[0] = out[2];
        for (int k = 1; k < 15; k++) begin
            @(posedge clk);
            #1;
            v15[k] = out[2];
        end
        chk("m3_n5", {17'h0, v15}, 32'h00001CE7);
        wr(2'd3, 8'hB6);
        wr(2'd2, 8'h06);
        wr(2'd2, 8'h00);
        v12    = '0;
        v12[0] = out[2];
        for (int k = 1; k < 12; k++) begin
            @(posedge clk);
            #1;
            v12[k] = out[2];
        end
        chk("m3_n6", {20'h0, v12}, 32'h000001C7);

        // Latch on ch0 in mode 2, count 0x1234; accesses every 2 cycles
        wr(2'd3, 8'h34);
        wr(2'd0, 8'h34);
        wr(2'd0, 8'h12);
        wr(2'd3, 8'h00);
        wr(2'd3, 8'h00);
        rd_chk("latch_lsb", 2'd0, 8'h34);
        rd_chk("latch_msb", 2'd0, 8'h12);
        rd_chk("live_lsb", 2'd0, 8'h2C);
        rd_chk("live_msb", 2'd0, 8'h12);
        wr(2'd3, 8'hC0);
        rd_chk("ch3_ctrl_lsb", 2'd0, 8'h26);
        rd_chk("ch3_ctrl_msb", 2'd0, 8'h12);
        wb(1'b1, 2'd3, 8'h00, 4'b0010, dummy);
        rd_chk("sel_ignored_lsb", 2'd0, 8'h20);

        // Held cyc/stb for 4 cycles on ch2 count writes
        wr(2'd3, 8'hB0);
        @(negedge clk);
        bus_if.cyc_i = 1'b1;
        bus_if.stb_i = 1'b1;
        bus_if.we_i  = 1'b1;
        bus_if.sel_i = 4'h1;
        bus_if.adr_i = 32'h8;
        bus_if.dat_i = 32'h03;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ackv[i] = bus_if.ack_o;
        end
        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        bus_if.we_i  = 1'b0;
        chk("hold_ack", {28'h0, ackv}, 32'h5);
        wr(2'd3, 8'h80);
        rd_chk("hold_lsb", 2'd2, 8'h03);
        rd_chk("hold_msb", 2'd2, 8'h03);

        // Count 0 in mode 2 on ch1 means a 65536-tick period
        wr(2'd3, 8'h74);
        wr(2'd1, 8'h00);
        wr(2'd1, 8'h00);
        first_low = 0;
        last      = 1'b0;
        for (int k = 1; k <= 65536; k++) begin
            @(posedge clk);
            #1;
            if (first_low == 0 && !out[1]) first_low = k;
            if (k == 65536) last = out[1];
        end
        chk("m2_n0_first_low", first_low, 32'd65535);
        chk("m2_n0_reload_high", {31'h0, last}, 32'h1);

        // Asynchronous reset during an ack cycle
        @(negedge clk);
        bus_if.cyc_i = 1'b1;
        bus_if.stb_i = 1'b1;
        bus_if.we_i  = 1'b0;
        bus_if.sel_i = 4'h1;
        bus_if.adr_i = 32'h4;
        @(posedge clk);
        #1;
        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", {29'h0, out}, 32'h0);
        chk("arst_ack", {31'h0, bus_if.ack_o}, 32'h0);
        chk("arst_dat", bus_if.dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_out", {29'h0, out}, 32'h0);
        rd_chk("post_rst_ch0", 2'd0, 8'h00);
        rd_chk("post_rst_ch1", 2'd1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pit_top.md
# pit_top

Simplified 8254-style programmable interval timer on the Wishbone peripheral bus. Three independent 16-bit down-counters generate periodic or one-shot outputs. The outputs drive the PIC's irq_i lines directly, so this block is the interrupt source upstream of the PIC. The PIC's rising-edge detection is the intended consumer of out_o.

## Interface
- PRESCALE, 1: clk_i cycles per counter tick (≥1); a tick is a 1-cycle enable when the prescaler wraps.
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte select; an access is honoured only when sel_i[0]=1, otherwise it is acked with no effect.
- adr_i  in  32  adr_i[3:2] selects the register: 0 = ch0, 1 = ch1, 2 = ch2, 3 = control; other bits are ignored.
- dat_i  in  32  write data; only [7:0] is used.
- dat_o  out  32  read data, {24'b0, byte}; registered.
- ack_o  out  1  1-cycle acknowledge.
- out_o  out  3  channel outputs; connect to PIC irq_i[2:0].

## Operation
- Bus access: an access executes in the cycle where cyc_i & stb_i & ~ack_o. In the next cycle ack_o=1, with dat_o valid for reads. Each access executes exactly once.
- Control word (write to address 3):
  - [7:6] channel select. Value 3 is ignored.
  - [5:4] RW mode: 00 = latch command, 01 = LSB only, 10 = MSB only, 11 = LSB then MSB.
  - [3:1] mode. Only modes 0, 2 and 3 are supported; mode 6 maps to 2, mode 7 maps to 3, and 1, 4, 5 map to 0.
  - [0] BCD bit, ignored (binary only).
  - A non-latch control word resets the channel's byte pointer and latch and stops counting until a new count is loaded. out is driven low for mode 0 and high for modes 2/3.
- Count write (address 0–2):
  - In RW mode 11, the first write is the LSB and the second is the MSB.
  - In RW modes 01/10 the other byte is 0.
  - When the count is complete it is held in a pending register and loaded into the counter on the next tick.
  - Count 0 means 65536. In modes 2/3 a count of 1 is treated as 2.
  - Writing a new count while running: mode 0 restarts at the next tick with out low. Modes 2/3 pick up the new count at the next reload.
- Mode 0 (interrupt on terminal count):
  - out stays low from load; the counter decrements each tick.
  - out goes high when the count reaches 0 and stays high until the next control word or count write.
  - The counter keeps wrapping (0 → FFFF) with no further effect.
- Mode 2 (rate generator): out is high; it goes low for exactly one tick when the count reaches 1, then the counter reloads N and out returns high. Period is N ticks.
- Mode 3 (square wave): after each reload of N, out is high for ceil(N/2) ticks and low for floor(N/2) ticks, repeating.
- Latch command:
  - Snapshots the counter into a 16-bit latch.
  - Reads then return the latch bytes per RW mode until all bytes have been read.
  - Further latch commands are ignored while a latch is unread.
- Reading:
  - Without a latch, a read returns live counter bytes per RW mode; in mode 11 reads alternate LSB and MSB.
  - A read of address 3 returns 0.
  - A channel never loaded reads 0.

## Timing
- Reset values: out_o=3'b000, ack_o=0, dat_o=0, all counters, latches and pending flags 0, prescaler 0, all channels idle with mode 0.
- Async reset mid-operation clears everything immediately. Counting resumes only after reprogramming.
- Register write effects are visible in the cycle ack_o is high.
- out_o is registered: it changes in the cycle after the tick on which the condition occurs.
- Simultaneous events:
  - A count write and a terminal count in the same cycle: the write wins; the mode 0 out stays low.
  - A latch command and a tick in the same cycle: the latch captures the pre-decrement value.
- PRESCALE=1 gives a tick every clk_i cycle.

## Structure
- pit_pkg holds:
  - mode constants MODE_TC=0, MODE_RATE=2, MODE_SQUARE=3;
  - RW encodings RW_LATCH, RW_LSB, RW_MSB, RW_BOTH;
  - address offsets ADR_CH0..ADR_CTRL.
- Sub-module pit_channel: one counter, pending register, latch, byte pointer and mode FSM. It has states IDLE, WAIT_LOAD, COUNTING and is instantiated 3×.
- pit_top contains the bus decode, the ack/dat_o registers and the prescaler.

## Test plan
All scenarios use PRESCALE=1.
- Reset: assert rst_i asynchronously mid-count → out_o=000, ack_o=0 and dat_o=0 in the same cycle; reads after release return 0.
- Mode 0, ch0: write ctrl 0x30, then 0x05 and 0x00 → out_o[0] low, then high exactly 5 ticks after the load tick; it stays high, and a new write of 0x05, 0x00 drives it low.
- Mode 2, ch1: ctrl 0x74, count 0x0004 → out_o[1] is low for 1 cycle every 4 cycles; the PIC sees one rising edge per period.
- Mode 3, ch2: ctrl 0xB6, count 5 → out_o[2] is high 3 cycles and low 2 cycles, repeating; with count 6 it is 3/3.
- Latch, ch0 in mode 2 with count 0x1234:
  - Write ctrl 0x00, then a second 0x00 before reading → the two reads return the first snapshot's LSB, then MSB.
  - The counter keeps running; a live read afterwards differs from the snapshot.
- Boundaries:
  - Count 0x0000 in mode 2 → period 65536 ticks.
  - ctrl 0xC0 (channel 3) → no effect.
  - A write with sel_i=4'b0010 → acked, no effect.
  - Holding cyc_i/stb_i for 4 cycles on a write → ack pulses once every other cycle and each pulse executes one write.
